// File: rtl/jfpjc_stream_compare.sv
// N-channel lockstep checker: per-channel FIFOs absorb skew, groups are compared against channel 0.
// Optional JPEG byte stuffing of the forwarded reference stream: JFPJC_STREAM_COMPARE_STUFF_EN.
module jfpjc_stream_compare #(
    parameter int CHANNELS    = 2,
    parameter int FIFO_DEPTH  = 16,
    parameter int COUNT_WIDTH = 24
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      clear,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [8*CHANNELS-1:0]     in_data,
    output logic                      out_valid,
    output logic [7:0]                out_data,
    output logic [COUNT_WIDTH-1:0]    compared_count,
    output logic                      mismatch,
    output logic [2:0]                mismatch_channel,
    output logic [COUNT_WIDTH-1:0]    mismatch_index,
    output logic [7:0]                mismatch_expected,
    output logic [7:0]                mismatch_actual,
    output logic                      overflow,
    output logic [CHANNELS-1:0]       overflow_mask
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]          PTR_ONE = (AW+1)'(1);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    logic [CHANNELS-1:0][AW:0]                 wptr_q, rptr_q;
    logic [CHANNELS-1:0][FIFO_DEPTH-1:0][7:0]  mem_q;
    logic [CHANNELS-1:0]                       empty, full, push, drop;
    logic [CHANNELS-1:0][7:0]                  head;
    logic                                      pop, in_stuff;
    logic                                      diff_any;
    logic [2:0]                                diff_ch;
    logic [7:0]                                diff_byte;

    logic                   out_valid_q, out_valid_d;
    logic [7:0]             out_data_q, out_data_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   mism_q, mism_d;
    logic [2:0]             mch_q, mch_d;
    logic [COUNT_WIDTH-1:0] midx_q, midx_d;
    logic [7:0]             mexp_q, mexp_d, mact_q, mact_d;
    logic                   ovf_q, ovf_d;
    logic [CHANNELS-1:0]    ovfm_q, ovfm_d;

`ifdef JFPJC_STREAM_COMPARE_STUFF_EN
    typedef enum logic {EMIT, STUFF} state_e;
    state_e state_q, state_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= EMIT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMIT:    if (pop && head[0] == 8'hFF) state_d = STUFF;
            STUFF:   state_d = EMIT;
            default: state_d = EMIT;
        endcase
        if (clear) state_d = EMIT;
    end

    assign in_stuff = (state_q == STUFF);
`else
    assign in_stuff = 1'b0;
`endif

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        pop = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            empty[c] = (wptr_q[c] == rptr_q[c]);
            full[c]  = (wptr_q[c][AW] != rptr_q[c][AW]) &&
                       (wptr_q[c][AW-1:0] == rptr_q[c][AW-1:0]);
            head[c]  = mem_q[c][rptr_q[c][AW-1:0]];
        end
        pop = (&(~empty)) && !in_stuff && !clear;
        for (int c = 0; c < CHANNELS; c++) begin
            push[c] = in_valid[c] && (!full[c] || pop) && !clear;
            drop[c] = in_valid[c] && full[c] && !pop && !clear;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (clear) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (push[c]) wptr_q[c] <= wptr_q[c] + PTR_ONE;
                if (pop)     rptr_q[c] <= rptr_q[c] + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int c = 0; c < CHANNELS; c++)
            if (push[c]) mem_q[c][wptr_q[c][AW-1:0]] <= in_data[8*c +: 8];
    end

    // Scan downward so the last hit is the lowest diverging channel.
    always_comb begin
        diff_any  = 1'b0;
        diff_ch   = 3'd0;
        diff_byte = 8'h00;
        for (int c = CHANNELS-1; c >= 1; c--) begin
            if (head[c] != head[0]) begin
                diff_any  = 1'b1;
                diff_ch   = 3'(c);
                diff_byte = head[c];
            end
        end
    end

    always_comb begin
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        count_d     = count_q;
        mism_d      = mism_q;
        mch_d       = mch_q;
        midx_d      = midx_q;
        mexp_d      = mexp_q;
        mact_d      = mact_q;
        ovf_d       = ovf_q | (|drop);
        ovfm_d      = ovfm_q | drop;
        if (pop) begin
            out_valid_d = 1'b1;
            out_data_d  = head[0];
            count_d     = count_q + CNT_ONE;
            if (diff_any && !mism_q) begin
                mism_d = 1'b1;
                mch_d  = diff_ch;
                midx_d = count_q;
                mexp_d = head[0];
                mact_d = diff_byte;
            end
        end else if (in_stuff) begin
            out_valid_d = 1'b1;
            out_data_d  = 8'h00;
        end
        if (clear) begin
            out_valid_d = 1'b0;
            out_data_d  = 8'h00;
            count_d     = '0;
            mism_d      = 1'b0;
            mch_d       = 3'd0;
            midx_d      = '0;
            mexp_d      = 8'h00;
            mact_d      = 8'h00;
            ovf_d       = 1'b0;
            ovfm_d      = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            count_q     <= '0;
            mism_q      <= 1'b0;
            mch_q       <= 3'd0;
            midx_q      <= '0;
            mexp_q      <= 8'h00;
            mact_q      <= 8'h00;
            ovf_q       <= 1'b0;
            ovfm_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            count_q     <= count_d;
            mism_q      <= mism_d;
            mch_q       <= mch_d;
            midx_q      <= midx_d;
            mexp_q      <= mexp_d;
            mact_q      <= mact_d;
            ovf_q       <= ovf_d;
            ovfm_q      <= ovfm_d;
        end
    end

    assign out_valid         = out_valid_q;
    assign out_data          = out_data_q;
    assign compared_count    = count_q;
    assign mismatch          = mism_q;
    assign mismatch_channel  = mch_q;
    assign mismatch_index    = midx_q;
    assign mismatch_expected = mexp_q;
    assign mismatch_actual   = mact_q;
    assign overflow          = ovf_q;
    assign overflow_mask     = ovfm_q;
endmodule

// File: tb/tb_jfpjc_stream_compare.sv
// Directed bench for jfpjc_stream_compare (3 channels, 8-deep FIFOs), either stuffing build.
module tb_jfpjc_stream_compare;
    localparam int CH = 3;
    localparam int CW = 24;

    logic            clock = 1'b0;
    logic            reset, clear;
    logic [CH-1:0]   in_valid;
    logic [8*CH-1:0] in_data;
    logic            out_valid;
    logic [7:0]      out_data;
    logic [CW-1:0]   compared_count, mismatch_index;
    logic            mismatch, overflow;
    logic [2:0]      mismatch_channel;
    logic [7:0]      mismatch_expected, mismatch_actual;
    logic [CH-1:0]   overflow_mask;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] outq[$];
    int         outcyc[$];
    logic [7:0] exp1[$];
    int         e0, bad;

    jfpjc_stream_compare #(.CHANNELS(CH), .FIFO_DEPTH(8), .COUNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data),
        .compared_count(compared_count), .mismatch(mismatch),
        .mismatch_channel(mismatch_channel), .mismatch_index(mismatch_index),
        .mismatch_expected(mismatch_expected), .mismatch_actual(mismatch_actual),
        .overflow(overflow), .overflow_mask(overflow_mask)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) if (!reset && out_valid) begin
        outq.push_back(out_data);
        outcyc.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [2:0] v, input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        in_valid = v;
        in_data  = {d2, d1, d0};
        tick();
        in_valid = '0;
    endtask

    task automatic idle(input int n);
        in_valid = '0;
        repeat (n) tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        outq.delete();
        outcyc.delete();
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = '0; in_data = '0;
        repeat (2) tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_count", compared_count, 0);
        chk("rst_mismatch", 32'(mismatch), 0);
        chk("rst_overflow", 32'({overflow, overflow_mask}), 0);
        chk("rst_mm_fields", 32'({mismatch_channel, mismatch_expected, mismatch_actual}), 0);
        reset = 1'b0;
        tick();

        // Identical streams 01 FF 7A.
`ifdef JFPJC_STREAM_COMPARE_STUFF_EN
        exp1 = '{8'h01, 8'hFF, 8'h00, 8'h7A};
`else
        exp1 = '{8'h01, 8'hFF, 8'h7A};
`endif
        drive(3'b111, 8'h01, 8'h01, 8'h01);
        e0 = cyc;
        drive(3'b111, 8'hFF, 8'hFF, 8'hFF);
        drive(3'b111, 8'h7A, 8'h7A, 8'h7A);
        idle(5);
        chk("id_nout", outq.size(), exp1.size());
        for (int i = 0; i < exp1.size() && i < outq.size(); i++)
            chk($sformatf("id_byte%0d", i), 32'(outq[i]), 32'(exp1[i]));
        if (outcyc.size() > 0) chk("id_latency", outcyc[0], e0 + 1);
        chk("id_count", compared_count, 3);
        chk("id_mismatch", 32'(mismatch), 0);

        // Channel 1 lags by 5 cycles.
        do_clear();
        for (int t = 0; t < 25; t++) begin
            drive({t < 20, t >= 5, t < 20}, 8'(8'h10 + t), 8'(8'h10 + t - 5), 8'(8'h10 + t));
            if (t == 5) e0 = cyc;
        end
        idle(4);
        chk("lag_nout", outq.size(), 20);
        bad = 0;
        for (int i = 0; i < outq.size(); i++) if (outq[i] !== 8'(8'h10 + i)) bad++;
        chk("lag_data_bad", bad, 0);
        if (outcyc.size() == 20) begin
            chk("lag_first", outcyc[0], e0 + 1);
            chk("lag_last", outcyc[19], e0 + 20);
        end
        chk("lag_count", compared_count, 20);
        chk("lag_overflow", 32'(overflow), 0);

        // First mismatch at byte 7 on channel 2, later one at byte 9 on channel 1.
        do_clear();
        for (int i = 0; i < 7; i++) drive(3'b111, 8'(8'h40 + i), 8'(8'h40 + i), 8'(8'h40 + i));
        idle(2);
        chk("mm_pre", 32'(mismatch), 0);
        drive(3'b111, 8'h54, 8'h54, 8'h55);
        idle(2);
        chk("mm_flag", 32'(mismatch), 1);
        chk("mm_ch", 32'(mismatch_channel), 2);
        chk("mm_idx", mismatch_index, 7);
        chk("mm_exp", 32'(mismatch_expected), 32'h54);
        chk("mm_act", 32'(mismatch_actual), 32'h55);
        drive(3'b111, 8'h48, 8'h48, 8'h48);
        drive(3'b111, 8'h49, 8'hAA, 8'h49);
        drive(3'b111, 8'h4A, 8'h4A, 8'h4B);
        drive(3'b111, 8'h4B, 8'h4B, 8'h4B);
        idle(3);
        chk("mm_hold", 32'({mismatch, mismatch_channel, mismatch_expected, mismatch_actual}),
            32'({1'b1, 3'd2, 8'h54, 8'h55}));
        chk("mm_hold_idx", mismatch_index, 7);
        chk("mm_count", compared_count, 12);

        // Overflow: channel 0 alone fills its 8-deep FIFO, then two more bytes drop.
        do_clear();
        for (int i = 0; i < 8; i++) drive(3'b001, 8'(8'h60 + i), 8'h00, 8'h00);
        chk("ovf_full_ok", 32'(overflow), 0);
        drive(3'b001, 8'h68, 8'h00, 8'h00);
        drive(3'b001, 8'h69, 8'h00, 8'h00);
        idle(1);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_mask", 32'(overflow_mask), 32'b001);
        chk("ovf_count", compared_count, 0);
        chk("ovf_nout", outq.size(), 0);

        // Clear in the same cycle as writes: those bytes and stale FIFO data vanish.
        clear = 1'b1;
        drive(3'b111, 8'h21, 8'h21, 8'h21);
        clear = 1'b0;
        outq.delete(); outcyc.delete();
        idle(3);
        chk("clr_nout", outq.size(), 0);
        chk("clr_flags", 32'({overflow, overflow_mask, mismatch}), 0);
        chk("clr_count", compared_count, 0);
        drive(3'b111, 8'h33, 8'h33, 8'h33);
        idle(3);
        chk("clr_after_nout", outq.size(), 1);
        if (outq.size() > 0) chk("clr_after_byte", 32'(outq[0]), 32'h33);
        chk("clr_after_count", compared_count, 1);

        // Async reset right after FF is emitted (STUFF pending when enabled).
        do_clear();
        drive(3'b111, 8'hFF, 8'hFF, 8'hFF);
        tick();
        chk("ar_ff_valid", 32'({out_valid, out_data}), 32'h1FF);
        #2 reset = 1'b1;
        #1 chk("ar_async_valid", 32'(out_valid), 0);
        #1 reset = 1'b0;
        idle(4);
        chk("ar_nout", outq.size(), 0);
        chk("ar_count", compared_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
